sseg_scan_capture: RTL

- Reader side of the seven-segment display bus: observes the active-low anode select lines and active-low segment lines driven to a scanned multi-digit display.
- Reconstructs the hex value shown on each digit position, with per-digit valid/blank flags and an error flag for illegal patterns.
- Used as an on-chip loopback monitor of the display driver, and as the scoreboard front-end in system benches.

---
 rtl/sseg_pkg.sv | 31 +++
 rtl/sseg2hex.sv | 41 ++++
 rtl/sseg_scan_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and segment encodings for the seven-segment bus monitor.
// Segment patterns are active-low, bit order gfedcba.
package sseg_pkg;

    typedef logic [6:0] sseg_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } scan_state_t;

    localparam sseg_t SSEG_0     = 7'b1000000;
    localparam sseg_t SSEG_1     = 7'b1111001;
    localparam sseg_t SSEG_2     = 7'b0100100;
    localparam sseg_t SSEG_3     = 7'b0110000;
    localparam sseg_t SSEG_4     = 7'b0011001;
    localparam sseg_t SSEG_5     = 7'b0010010;
    localparam sseg_t SSEG_6     = 7'b0000010;
    localparam sseg_t SSEG_7     = 7'b1111000;
    localparam sseg_t SSEG_8     = 7'b0000000;
    localparam sseg_t SSEG_9     = 7'b0010000;
    localparam sseg_t SSEG_A     = 7'b0001000;
    localparam sseg_t SSEG_B     = 7'b0000011;
    localparam sseg_t SSEG_C     = 7'b1000110;
    localparam sseg_t SSEG_D     = 7'b0100001;
    localparam sseg_t SSEG_E     = 7'b0000110;
    localparam sseg_t SSEG_F     = 7'b0001110;
    localparam sseg_t SSEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg2hex.sv
// Combinational decoder from an active-low segment pattern to a hex nibble.
// Patterns outside the 16 glyphs and the all-off pattern are flagged illegal.
module sseg2hex
    import sseg_pkg::*;
(
    input  sseg_t      seg,
    output logic [3:0] hex,
    output logic       is_legal,
    output logic       is_blank
);

    always_comb begin
        hex      = 4'h0;
        is_legal = 1'b1;
        is_blank = 1'b0;
        case (seg)
            SSEG_0:     hex = 4'h0;
            SSEG_1:     hex = 4'h1;
            SSEG_2:     hex = 4'h2;
            SSEG_3:     hex = 4'h3;
            SSEG_4:     hex = 4'h4;
            SSEG_5:     hex = 4'h5;
            SSEG_6:     hex = 4'h6;
            SSEG_7:     hex = 4'h7;
            SSEG_8:     hex = 4'h8;
            SSEG_9:     hex = 4'h9;
            SSEG_A:     hex = 4'hA;
            SSEG_B:     hex = 4'hB;
            SSEG_C:     hex = 4'hC;
            SSEG_D:     hex = 4'hD;
            SSEG_E:     hex = 4'hE;
            SSEG_F:     hex = 4'hF;
            SSEG_BLANK: begin
                is_legal = 1'b0;
                is_blank = 1'b1;
            end
            default:    is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Monitor for a scanned seven-segment display: synchronizes anode/segment
// lines, waits for a stable single-digit selection, and captures its value.
//
//   state | meaning
//   IDLE  | zero or several anodes low; nothing to capture
//   TRACK | one anode low, waiting for the inputs to stay stable
//   HOLD  | this selection already captured; wait for the next change
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS-1:0]         an_in,
    input  logic [6:0]                    sseg_in,
    input  logic                          clr_err,
    output logic [4*NUM_DIGITS-1:0]       hex_out,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic [NUM_DIGITS-1:0]         digit_blank,
    output logic                          update,
    output logic [$clog2(NUM_DIGITS)-1:0] update_idx,
    output logic                          err_pulse,
    output logic                          err_sticky
);

    localparam int          SW    = NUM_DIGITS + 7;
    localparam int          IDX_W = $clog2(NUM_DIGITS);
    localparam logic [7:0]  STB   = 8'(STABLE_CYCLES);

    logic [SW-1:0]         sync_1, s_q, s_prev;
    logic [NUM_DIGITS-1:0] an_q;
    sseg_t                 seg_q;
    logic                  changed;
    logic [7:0]            cnt;
    logic [3:0]            low_cnt;
    logic [IDX_W-1:0]      low_idx;
    logic                  one_sel;
    scan_state_t           state_q, state_d;
    logic                  capture;
    logic [3:0]            dec_hex;
    logic                  dec_legal, dec_blank, dec_bad;

    assign an_q    = s_q[SW-1:7];
    assign seg_q   = s_q[6:0];
    assign changed = (s_q != s_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '1;
            s_q    <= '1;
            s_prev <= '1;
        end else begin
            sync_1 <= {an_in, sseg_in};
            s_q    <= sync_1;
            s_prev <= s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= 8'd1;
        end else if (cnt < STB) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_sel = (low_cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture fires on the edge where the counter steps up to STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (changed) begin
            state_d = one_sel ? TRACK : IDLE;
        end else begin
            case (state_q)
                TRACK: begin
                    if (cnt == STB - 8'd1) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

    sseg2hex u_dec (
        .seg      (seg_q),
        .hex      (dec_hex),
        .is_legal (dec_legal),
        .is_blank (dec_blank)
    );

    assign dec_bad = !dec_legal && !dec_blank;

    // Sticky also sees err_pulse so a clear landing on the pulse cycle loses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out     <= '0;
            digit_valid <= '0;
            digit_blank <= '1;
            update      <= 1'b0;
            update_idx  <= '0;
            err_pulse   <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            update     <= capture;
            err_pulse  <= capture && dec_bad;
            err_sticky <= (capture && dec_bad) || err_pulse || (err_sticky && !clr_err);
            if (capture) begin
                update_idx           <= low_idx;
                digit_valid[low_idx] <= dec_legal;
                digit_blank[low_idx] <= dec_blank;
                if (dec_legal) begin
                    hex_out[4*low_idx +: 4] <= dec_hex;
                end
            end
        end
    end

endmodule
